// File: rtl/txt_writer.sv
// txt_writer: character-stream writer for the 40x24 interleaved text page.
// Accepts bytes over a valid/ready handshake, places printable characters at
// a hardware cursor and handles CR, BS, line wrap and end-of-page handling.
// Build option: define TXT_WRITER_SCROLL_EN to scroll the page up on a newline
// at row 23. Without it the cursor wraps to row 0 and that row is blanked.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// CLEAR     | blanking the whole page after reset, one cell per cycle
// IDLE      | ready for a character
// PUT       | writing the latched character at the cursor
// NEWLINE   | moving the cursor to column 0 of the next row
// SCROLL_RD | presenting the source cell (row below) on the read port
// SCROLL_WR | writing the returned byte into the destination cell
// CLRLINE   | blanking the cursor row after a scroll or page wrap
module txt_writer #(
   parameter logic [15:0] BASE  = 16'h0400,
   parameter logic [7:0]  BLANK = 8'hA0
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        ch_valid,
   input  logic [7:0]  ch_data,
   output logic        ch_ready,
   output logic [15:0] txt_wadr,
   output logic [7:0]  txt_wdata,
   output logic        txt_we,
   output logic [15:0] txt_radr,
   input  logic [7:0]  txt_rq,
   output logic [4:0]  cur_row,
   output logic [5:0]  cur_col,
   output logic        busy
);

   localparam logic [4:0] LAST_ROW = 5'd23;
   localparam logic [5:0] LAST_COL = 6'd39;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      PUT,
      NEWLINE,
`ifdef TXT_WRITER_SCROLL_EN
      SCROLL_RD,
      SCROLL_WR,
`endif
      CLRLINE
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  row_q, sc_row_q;
   logic [5:0]  col_q, sc_col_q;
   logic [6:0]  ch_q;
   logic        hold_q;
   logic        we_c;
   logic [15:0] wadr_c;
   logic [7:0]  wdata_c;
   logic [6:0]  code;
   logic        hs;
   logic        unused_in;

   // Rows 0..7 are 0x80 apart; each group of eight rows is offset by 40 bytes.
   function automatic logic [15:0] adr(input logic [4:0] r, input logic [5:0] c);
      logic [15:0] band;
      band = 16'd40 * {14'd0, r[4:3]};
      return BASE + {6'd0, r[2:0], 7'd0} + band + {10'd0, c};
   endfunction

   assign code = ch_data[6:0];
   assign hs   = ch_valid & ch_ready;

   // Outputs are forced quiet while reset is held, whatever the state register holds.
   assign ch_ready  = ~reset & (state_q == IDLE) & ~hold_q;
   assign busy      = reset | (state_q != IDLE);
   assign txt_we    = we_c & ~reset;
   assign txt_wadr  = reset ? 16'd0 : wadr_c;
   assign txt_wdata = reset ? 8'd0 : wdata_c;
   assign cur_row   = reset ? 5'd0 : row_q;
   assign cur_col   = reset ? 6'd0 : col_q;

`ifdef TXT_WRITER_SCROLL_EN
   logic [15:0] radr_q;
   logic [15:0] rd_adr;
   assign rd_adr    = adr(sc_row_q + 5'd1, sc_col_q);
   assign txt_radr  = reset ? 16'd0 : ((state_q == SCROLL_RD) ? rd_adr : radr_q);
   assign unused_in = ch_data[7];

   // Read address register keeps the last presented address between scroll reads.
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         radr_q <= 16'd0;
      else if (state_q == SCROLL_RD)
         radr_q <= rd_adr;
   end
`else
   assign txt_radr  = 16'd0;
   assign unused_in = ^{txt_rq, ch_data[7]};
`endif

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         state_q <= CLEAR;
      else
         state_q <= state_d;
   end

   // Next state and buffer write port.
   always_comb begin
      state_d = state_q;
      we_c    = 1'b0;
      wadr_c  = 16'd0;
      wdata_c = 8'd0;
      case (state_q)
         CLEAR: begin
            we_c    = 1'b1;
            wadr_c  = adr(sc_row_q, sc_col_q);
            wdata_c = BLANK;
            if (sc_row_q == LAST_ROW && sc_col_q == LAST_COL)
               state_d = IDLE;
         end
         IDLE: begin
            if (hs) begin
               if (code >= 7'h20)
                  state_d = PUT;
               else if (code == 7'h0D)
                  state_d = NEWLINE;
            end
         end
         PUT: begin
            we_c    = 1'b1;
            wadr_c  = adr(row_q, col_q);
            wdata_c = {1'b1, ch_q};
            state_d = (col_q == LAST_COL) ? NEWLINE : IDLE;
         end
         NEWLINE: begin
            if (row_q != LAST_ROW)
               state_d = IDLE;
            else
`ifdef TXT_WRITER_SCROLL_EN
               state_d = SCROLL_RD;
`else
               state_d = CLRLINE;
`endif
         end
`ifdef TXT_WRITER_SCROLL_EN
         SCROLL_RD: state_d = SCROLL_WR;
         SCROLL_WR: begin
            we_c    = 1'b1;
            wadr_c  = adr(sc_row_q, sc_col_q);
            wdata_c = txt_rq;
            if (sc_row_q == LAST_ROW - 5'd1 && sc_col_q == LAST_COL)
               state_d = CLRLINE;
            else
               state_d = SCROLL_RD;
         end
`endif
         CLRLINE: begin
            we_c    = 1'b1;
            wadr_c  = adr(row_q, sc_col_q);
            wdata_c = BLANK;
            if (sc_col_q == LAST_COL)
               state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   // Cursor, sweep counters, latched character and the one-cycle ready drop.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         row_q    <= 5'd0;
         col_q    <= 6'd0;
         sc_row_q <= 5'd0;
         sc_col_q <= 6'd0;
         ch_q     <= 7'd0;
         hold_q   <= 1'b0;
      end else begin
         hold_q <= 1'b0;
         case (state_q)
            CLEAR: begin
               if (sc_col_q == LAST_COL) begin
                  sc_col_q <= 6'd0;
                  if (sc_row_q == LAST_ROW) begin
                     sc_row_q <= 5'd0;
                     row_q    <= 5'd0;
                     col_q    <= 6'd0;
                  end else begin
                     sc_row_q <= sc_row_q + 5'd1;
                  end
               end else begin
                  sc_col_q <= sc_col_q + 6'd1;
               end
            end
            IDLE: begin
               if (hs) begin
                  ch_q <= code;
                  if (code < 7'h20 && code != 7'h0D) begin
                     hold_q <= 1'b1;
                     if (code == 7'h08 && col_q != 6'd0)
                        col_q <= col_q - 6'd1;
                  end
               end
            end
            PUT: col_q <= (col_q == LAST_COL) ? 6'd0 : col_q + 6'd1;
            NEWLINE: begin
               col_q    <= 6'd0;
               sc_row_q <= 5'd0;
               sc_col_q <= 6'd0;
               if (row_q != LAST_ROW)
                  row_q <= row_q + 5'd1;
`ifndef TXT_WRITER_SCROLL_EN
               else
                  row_q <= 5'd0;
`endif
            end
`ifdef TXT_WRITER_SCROLL_EN
            SCROLL_WR: begin
               if (sc_col_q == LAST_COL) begin
                  sc_col_q <= 6'd0;
                  sc_row_q <= (sc_row_q == LAST_ROW - 5'd1) ? 5'd0 : sc_row_q + 5'd1;
               end else begin
                  sc_col_q <= sc_col_q + 6'd1;
               end
            end
`endif
            CLRLINE: sc_col_q <= (sc_col_q == LAST_COL) ? 6'd0 : sc_col_q + 6'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_txt_writer.sv
// Testbench for txt_writer: directed steps plus a random character stream,
// checked against a 24x40 page model with a cursor and latency rules.
module tb_txt_writer;

   logic        CLOCK_50;
   logic        reset;
   logic        ch_valid;
   logic [7:0]  ch_data;
   logic        ch_ready;
   logic [15:0] txt_wadr;
   logic [7:0]  txt_wdata;
   logic        txt_we;
   logic [15:0] txt_radr;
   logic [7:0]  txt_rq;
   logic [4:0]  cur_row;
   logic [5:0]  cur_col;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int wcount = 0;
   bit radr_seen = 0;

   logic [7:0] mem [0:65535];
   logic [7:0] grid [24][40];
   int mr, mc;

   txt_writer dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .ch_valid (ch_valid),
      .ch_data  (ch_data),
      .ch_ready (ch_ready),
      .txt_wadr (txt_wadr),
      .txt_wdata(txt_wdata),
      .txt_we   (txt_we),
      .txt_radr (txt_radr),
      .txt_rq   (txt_rq),
      .cur_row  (cur_row),
      .cur_col  (cur_col),
      .busy     (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Text buffer: registered read, byte write.
   always @(posedge CLOCK_50) begin
      if (txt_we) begin
         mem[txt_wadr] <= txt_wdata;
         wcount <= wcount + 1;
      end
      txt_rq <= mem[txt_radr];
   end

   always @(negedge CLOCK_50)
      if (!reset && txt_radr !== 16'h0) radr_seen <= 1'b1;

   function automatic logic [15:0] cell_adr(input int r, input int c);
      return 16'(32'h0400 + 128 * (r % 8) + 40 * (r / 8) + c);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 40; c++) grid[r][c] = 8'hA0;
      mr = 0;
      mc = 0;
   endtask

   task automatic model_newline(output int extra);
      mc = 0;
      if (mr < 23) begin
         mr++;
         extra = 0;
      end else begin
`ifdef TXT_WRITER_SCROLL_EN
         for (int r = 0; r < 23; r++)
            for (int c = 0; c < 40; c++) grid[r][c] = grid[r+1][c];
         for (int c = 0; c < 40; c++) grid[23][c] = 8'hA0;
         extra = 1880;
`else
         mr = 0;
         for (int c = 0; c < 40; c++) grid[0][c] = 8'hA0;
         extra = 40;
`endif
      end
   endtask

   task automatic model_char(input logic [7:0] b, output int lat, output bit puts,
                             output logic [15:0] padr, output logic [7:0] pdat);
      int code, extra;
      code = int'(b) & 32'h7F;
      puts = 0;
      padr = 16'h0;
      pdat = 8'h0;
      lat  = 2;
      if (code >= 32'h20) begin
         puts = 1;
         padr = cell_adr(mr, mc);
         pdat = 8'(code | 32'h80);
         grid[mr][mc] = pdat;
         if (mc < 39) mc++;
         else begin
            model_newline(extra);
            lat = 3 + extra;
         end
      end else if (code == 32'h0D) begin
         model_newline(extra);
         lat = 2 + extra;
      end else if (code == 32'h08) begin
         if (mc > 0) mc--;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int lat, n, w0;
      bit puts;
      logic [15:0] padr, wadr1;
      logic [7:0] pdat, wdata1;
      logic we1;
      we1 = 1'b0; wadr1 = 16'h0; wdata1 = 8'h0;
      n = 0;
      while (ch_ready !== 1'b1 && n < 4000) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (n >= 4000) chk("ready_timeout", {31'd0, ch_ready}, 32'd1);
      model_char(b, lat, puts, padr, pdat);
      w0 = wcount;
      ch_valid = 1'b1;
      ch_data  = b;
      @(posedge CLOCK_50);
      #1 ch_valid = 1'b0;
      n = 0;
      do begin
         @(negedge CLOCK_50);
         n++;
         if (n == 1) begin
            we1 = txt_we; wadr1 = txt_wadr; wdata1 = txt_wdata;
            chk("ready_drop", {31'd0, ch_ready}, 32'd0);
         end
      end while (ch_ready !== 1'b1 && n < 4000);
      chk("latency", n, lat);
      chk("put_we", {31'd0, we1}, {31'd0, puts});
      if (puts) begin
         chk("put_adr", {16'd0, wadr1}, {16'd0, padr});
         chk("put_data", {24'd0, wdata1}, {24'd0, pdat});
      end else if (lat == 2) begin
         chk("no_write", wcount - w0, 0);
      end
      chk("cur_row", {27'd0, cur_row}, mr);
      chk("cur_col", {26'd0, cur_col}, mc);
   endtask

   task automatic chk_reset_outs();
      chk("rst_ready", {31'd0, ch_ready}, 0);
      chk("rst_we", {31'd0, txt_we}, 0);
      chk("rst_wadr", {16'd0, txt_wadr}, 0);
      chk("rst_wdata", {24'd0, txt_wdata}, 0);
      chk("rst_radr", {16'd0, txt_radr}, 0);
      chk("rst_row", {27'd0, cur_row}, 0);
      chk("rst_col", {26'd0, cur_col}, 0);
      chk("rst_busy", {31'd0, busy}, 1);
   endtask

   // Called just after the first clock edge with reset released.
   task automatic check_clear();
      int bad;
      logic [15:0] first, last;
      bad = 0; first = 16'h0; last = 16'h0;
      for (int i = 0; i < 960; i++) begin
         @(negedge CLOCK_50);
         if (txt_we !== 1'b1 || txt_wadr !== cell_adr(i / 40, i % 40) ||
             txt_wdata !== 8'hA0 || ch_ready !== 1'b0) bad++;
         if (i == 0) first = txt_wadr;
         if (i == 959) last = txt_wadr;
      end
      chk("clear_cells", bad, 0);
      chk("clear_first", {16'd0, first}, 32'h0400);
      chk("clear_last", {16'd0, last}, 32'h07F7);
      @(negedge CLOCK_50);
      chk("clear_ready", {31'd0, ch_ready}, 1);
      chk("clear_we_off", {31'd0, txt_we}, 0);
      chk("clear_row", {27'd0, cur_row}, 0);
      chk("clear_col", {26'd0, cur_col}, 0);
      chk("clear_busy", {31'd0, busy}, 0);
      model_clear();
   endtask

   task automatic grid_check(input string tag);
      int bad;
      bad = 0;
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 40; c++)
            if (mem[cell_adr(r, c)] !== grid[r][c]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic goto_row23();
      int g;
      g = 0;
      while (mr != 23 && g < 40) begin
         send(8'h0D);
         g++;
      end
   endtask

   initial begin
      int k, lat_dummy, exp_row;
      logic [7:0] b;
      reset = 1'b1;
      ch_valid = 1'b0;
      ch_data = 8'h00;
      repeat (3) begin
         @(negedge CLOCK_50);
         chk_reset_outs();
      end
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      check_clear();

      // Backspace at column 0 and a bell are both no-ops.
      send(8'h08);
      send(8'h07);
      send(8'h48);
      chk("h_mem", {24'd0, mem[16'h0400]}, 32'hC8);
      send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
      send(8'h08);
      chk("bs_col", {26'd0, cur_col}, 4);
      send(8'h0D);
      chk("cr_row", {27'd0, cur_row}, 1);
      chk("cr_col", {26'd0, cur_col}, 0);
      send(8'hC1);
      chk("a_mem", {24'd0, mem[16'h0480]}, 32'hC1);

      // Wrap: 40 characters from (8,0).
      while (mr < 8) send(8'h0D);
      for (int i = 0; i < 40; i++) send(8'h58);
      chk("wrap_row", {27'd0, cur_row}, 9);
      chk("wrap_col", {26'd0, cur_col}, 0);
      chk("wrap_first", {24'd0, mem[16'h0428]}, 32'hD8);
      chk("wrap_last", {24'd0, mem[16'h044F]}, 32'hD8);
      grid_check("grid_wrap");

      // Random stream of printables, CR, BS and other controls, bit 7 random.
      for (int i = 0; i < 150; i++) begin
         k = int'($urandom_range(0, 23));
         if (k < 4) b = 8'h0D;
         else if (k < 6) b = 8'h08;
         else if (k == 6) b = 8'($urandom_range(0, 31));
         else b = 8'($urandom_range(32, 127));
         if ($urandom_range(0, 1) == 1) b = b | 8'h80;
         send(b);
      end
      grid_check("grid_random");

      // Newline on the last row.
      goto_row23();
      send(8'h0D);
`ifdef TXT_WRITER_SCROLL_EN
      exp_row = 23;
`else
      exp_row = 0;
`endif
      chk("last_nl_row", {27'd0, cur_row}, exp_row);
      chk("last_nl_col", {26'd0, cur_col}, 0);
      chk("last_nl_blank", {24'd0, mem[cell_adr(exp_row, 0)]}, 32'hA0);
      grid_check("grid_last_nl");
`ifdef TXT_WRITER_SCROLL_EN
      chk("radr_used", {31'd0, radr_seen}, 1);
`else
      chk("radr_quiet", {31'd0, radr_seen}, 0);
`endif

      // Reset in the middle of the row-23 newline operation.
      goto_row23();
      ch_valid = 1'b1;
      ch_data  = 8'h0D;
      @(posedge CLOCK_50);
      #1 ch_valid = 1'b0;
`ifdef TXT_WRITER_SCROLL_EN
      repeat (500) @(negedge CLOCK_50);
`else
      repeat (20) @(negedge CLOCK_50);
`endif
      chk("mid_busy", {31'd0, busy}, 1);
      reset = 1'b1;
      @(negedge CLOCK_50);
      chk_reset_outs();
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      check_clear();
      grid_check("grid_after_abort");
      send(8'h5A);
      chk("post_abort_mem", {24'd0, mem[16'h0400]}, 32'hDA);
      lat_dummy = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
